// File: rtl/clk_reset_seq.sv
// rtl/clk_reset_seq.sv - PLL lock synchroniser, staggered reset release and per-channel clock-enable dividers
module clk_reset_seq #(
  parameter int                      N_CH        = 4,
  parameter int                      DIV_W       = 16,
  parameter logic [N_CH*DIV_W-1:0]   DIV         = {N_CH{16'd1}},
  parameter int                      HOLD_CYCLES = 1024,
  parameter int                      STAGGER     = 16,
  parameter int                      LOSS_W      = 8
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                pll_lock,
  output logic [N_CH-1:0]     rst_out,
  output logic [N_CH-1:0]     ce_out,
  output logic                ready,
  output logic [LOSS_W-1:0]   lock_loss_cnt
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STG_LAST  = SW'(STAGGER - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                lock_meta_q, lock_s_q;
  logic [HW-1:0]       hold_q, hold_d;
  logic [SW-1:0]       stg_q, stg_d;
  logic [N_CH-1:0]     rst_q, rst_d;
  logic [LOSS_W-1:0]   loss_q, loss_d;
  logic                lock_lost;

  // Release and run are the only states where losing lock counts as an event.
  assign lock_lost = ((state_q == RELEASE) || (state_q == RUN)) && !lock_s_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= WAIT_LOCK;
      hold_q      <= '0;
      stg_q       <= '0;
      rst_q       <= '1;
      loss_q      <= '0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
      state_q     <= state_d;
      hold_q      <= hold_d;
      stg_q       <= stg_d;
      rst_q       <= rst_d;
      loss_q      <= loss_d;
    end
  end

  // Resets release lowest bit first, so shifting in a zero clears the next channel.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stg_d   = stg_q;
    rst_d   = rst_q;
    loss_d  = loss_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = HOLD;
          hold_d  = '0;
        end
      end
      HOLD: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          hold_d  = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = RELEASE;
          rst_d   = rst_q << 1;
          stg_d   = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      RELEASE: begin
        if (stg_q == STG_LAST) begin
          stg_d = '0;
          if (!rst_q[N_CH-1]) state_d = RUN;
          else                rst_d   = rst_q << 1;
        end else begin
          stg_d = stg_q + SW'(1);
        end
      end
      RUN: ;
      default: state_d = WAIT_LOCK;
    endcase
    if (lock_lost) begin
      state_d = WAIT_LOCK;
      rst_d   = '1;
      stg_d   = '0;
      hold_d  = '0;
      if (loss_q != '1) loss_d = loss_q + LOSS_W'(1);
    end
  end

  always_comb begin
    ready         = (state_q == RUN);
    rst_out       = rst_q;
    lock_loss_cnt = loss_q;
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_div
    localparam logic [DIV_W-1:0] DIV_RAW  = DIV[k*DIV_W +: DIV_W];
    localparam logic [DIV_W-1:0] DIV_LAST = (DIV_RAW == '0) ? '0 : DIV_RAW - DIV_W'(1);
    logic [DIV_W-1:0] cnt_q;

    always_ff @(posedge clk_in) begin
      if (reset || rst_q[k] || lock_lost) cnt_q <= '0;
      else if (cnt_q == DIV_LAST)         cnt_q <= '0;
      else                                cnt_q <= cnt_q + DIV_W'(1);
    end

    assign ce_out[k] = (cnt_q == DIV_LAST) & ~rst_q[k];
  end

endmodule

// File: tb/tb_clk_reset_seq.sv
// tb/tb_clk_reset_seq.sv - scoreboard bench for clk_reset_seq lock sequencing, dividers and loss counting
module tb_clk_reset_seq;
  localparam int N_CH = 3;
  localparam int DIV_W = 16;
  localparam int H = 8;
  localparam int S = 4;
  localparam int LOSS_W = 2;
  localparam logic [N_CH*DIV_W-1:0] DIVP = {16'd10, 16'd4, 16'd1};

  logic clk_in = 1'b0;
  logic reset = 1'b1;
  logic pll_lock = 1'b0;
  logic [N_CH-1:0] rst_out;
  logic [N_CH-1:0] ce_out;
  logic ready;
  logic [LOSS_W-1:0] lock_loss_cnt;

  clk_reset_seq #(
    .N_CH(N_CH), .DIV_W(DIV_W), .DIV(DIVP),
    .HOLD_CYCLES(H), .STAGGER(S), .LOSS_W(LOSS_W)
  ) dut (
    .clk_in(clk_in), .reset(reset), .pll_lock(pll_lock),
    .rst_out(rst_out), .ce_out(ce_out), .ready(ready), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [N_CH-1:0]   rst;
    logic [N_CH-1:0]   ce;
    logic              rdy;
    logic [LOSS_W-1:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int tests_run = 0;
  int tests_failed = 0;
  int run_c = 0;
  int run_d1 = 0;
  logic [LOSS_W-1:0] m_loss = '0;
  logic m_rst0 = 1'b1;
  int divs[N_CH] = '{1, 4, 10};

  // Expected outputs after an edge come from the lock-timeline offsets: n edges since the
  // first pll_lock=1 sample, valid while the sample two edges back was still high.
  task automatic step(input logic lk, input logic rs);
    exp_t e;
    exp_t got;
    int good, n, rel, first;
    reset = rs;
    pll_lock = lk;
    good = run_d1;
    e.rst = '1;
    e.ce = '0;
    e.rdy = 1'b0;
    if (rs) begin
      m_loss = '0;
      run_c = 0;
      run_d1 = 0;
    end else begin
      if (good > 0) begin
        n = good + 1;
        for (int k = 0; k < N_CH; k++) begin
          rel = 2 + H + k * S;
          first = rel + divs[k] - 1;
          if (n >= rel) e.rst[k] = 1'b0;
          if (n >= first && ((n - first) % divs[k]) == 0) e.ce[k] = 1'b1;
        end
        e.rdy = (n >= 2 + H + N_CH * S);
      end else if (!m_rst0 && m_loss != '1) begin
        m_loss = m_loss + 1'b1;
      end
      run_d1 = run_c;
      run_c = lk ? run_c + 1 : 0;
    end
    e.cnt = m_loss;
    m_rst0 = e.rst[0];
    sbq.push_back(e);
    @(posedge clk_in);
    #1;
    got = {rst_out, ce_out, ready, lock_loss_cnt};
    e = sbq.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL sb t=%0t rst=%b/%b ce=%b/%b ready=%b/%b cnt=%0d/%0d (actual/required)",
               $time, got.rst, e.rst, got.ce, e.ce, got.rdy, e.rdy, got.cnt, e.cnt);
    end
  endtask

  task automatic steps(input int n, input logic lk);
    for (int i = 0; i < n; i++) step(lk, 1'b0);
  endtask

  task automatic test_reset;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    tests_run++;
    if (rst_out !== 3'b111 || ce_out !== 3'b000 || ready !== 1'b0 || lock_loss_cnt !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_state rst=%b ce=%b ready=%b cnt=%0d required 111 000 0 0",
               rst_out, ce_out, ready, lock_loss_cnt);
    end
    steps(50, 1'b0);
  endtask

  task automatic test_hold_glitch;
    steps(5, 1'b1);
    steps(3, 1'b0);
    steps(10, 1'b1);
    tests_run++;
    if (rst_out !== 3'b111) begin
      tests_failed++;
      $display("FAIL hold_recount rst=%b required 111", rst_out);
    end
    step(1'b1, 1'b0);
    tests_run++;
    if (rst_out !== 3'b110 || lock_loss_cnt !== 2'd0) begin
      tests_failed++;
      $display("FAIL hold_release rst=%b cnt=%0d required 110 0", rst_out, lock_loss_cnt);
    end
    steps(30, 1'b1);
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL run_ready ready=%b required 1", ready);
    end
  endtask

  task automatic test_lock_loss;
    steps(3, 1'b0);
    tests_run++;
    if (rst_out !== 3'b111 || ce_out !== 3'b000 || ready !== 1'b0 || lock_loss_cnt !== 2'd1) begin
      tests_failed++;
      $display("FAIL loss_l2 rst=%b ce=%b ready=%b cnt=%0d required 111 000 0 1",
               rst_out, ce_out, ready, lock_loss_cnt);
    end
    steps(40, 1'b1);
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL relock_ready ready=%b required 1", ready);
    end
  endtask

  task automatic test_saturation;
    logic [LOSS_W-1:0] sat_exp[4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    step(1'b0, 1'b1);
    steps(25, 1'b1);
    for (int i = 0; i < 4; i++) begin
      steps(3, 1'b0);
      tests_run++;
      if (lock_loss_cnt !== sat_exp[i]) begin
        tests_failed++;
        $display("FAIL loss_sat[%0d] cnt=%0d required %0d", i, lock_loss_cnt, sat_exp[i]);
      end
      steps(25, 1'b1);
    end
  endtask

  task automatic test_reset_in_release;
    steps(3, 1'b0);
    steps(11, 1'b1);
    tests_run++;
    if (rst_out !== 3'b110 || lock_loss_cnt !== 2'd3) begin
      tests_failed++;
      $display("FAIL pre_reset rst=%b cnt=%0d required 110 3", rst_out, lock_loss_cnt);
    end
    step(1'b1, 1'b1);
    tests_run++;
    if (rst_out !== 3'b111 || ready !== 1'b0 || lock_loss_cnt !== 2'd0) begin
      tests_failed++;
      $display("FAIL mid_reset rst=%b ready=%b cnt=%0d required 111 0 0",
               rst_out, ready, lock_loss_cnt);
    end
    steps(30, 1'b1);
    tests_run++;
    if (ready !== 1'b1 || lock_loss_cnt !== 2'd0) begin
      tests_failed++;
      $display("FAIL restart ready=%b cnt=%0d required 1 0", ready, lock_loss_cnt);
    end
  endtask

  initial begin
    #1;
    test_reset;
    test_hold_glitch;
    test_lock_loss;
    test_saturation;
    test_reset_in_release;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
